// File: rtl/axi_lite_mem_slave_if.sv
// AXI4-Lite bus bundle between a single master and the word-memory responder.
// The master modport drives address/data/VALID and the response READYs; the
// slave modport drives the channel READYs and the response beats.
interface axi_lite_mem_slave_if #(
  parameter int ADDR_W = 64
);
  logic [ADDR_W-1:0] AWADDR;
  logic              AWVALID;
  logic              AWREADY;
  logic [63:0]       WDATA;
  logic [7:0]        WSTRB;
  logic              WVALID;
  logic              WREADY;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;
  logic [ADDR_W-1:0] ARADDR;
  logic              ARVALID;
  logic              ARREADY;
  logic [63:0]       RDATA;
  logic [1:0]        RRESP;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WSTRB, WVALID, BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID, ARREADY, RDATA, RRESP, RVALID
  );
endinterface

// File: rtl/axi_lite_mem_slave.sv
// AXI4-Lite responder backed by a DEPTH x 64-bit word memory at byte address BASE.
// Single-beat reads and writes on independent channels, one response each,
// SLVERR outside [BASE, BASE + DEPTH*8). Memory is not cleared by RST.
// Optional macro AXI_SLV_WSTRB_EN: honour WSTRB byte lanes on writes; when
// undefined, every in-range write replaces the whole word.
//
// Write FSM:                              Read FSM:
//   W_IDLE | nothing captured               R_IDLE | ARREADY high
//   W_HALF | exactly one of AW / W held     R_DATA | RVALID high
//   W_RESP | BVALID high
module axi_lite_mem_slave #(
  parameter int          ADDR_W = 64,
  parameter int          DEPTH  = 256,
  parameter logic [63:0] BASE   = 64'h0
) (
  input logic                 CLK,
  input logic                 RST,
  axi_lite_mem_slave_if.slave S_DM_AXI
);

  localparam int                IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] BASE_A = BASE[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] SPAN_A = ADDR_W'(DEPTH) << 3;
  localparam logic [1:0]        OKAY   = 2'b00;
  localparam logic [1:0]        SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_HALF, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // Borrow bit of the widened subtraction catches addresses below BASE.
  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    logic [ADDR_W:0] diff;
    diff = {1'b0, a} - {1'b0, BASE_A};
    return !diff[ADDR_W] && (diff[ADDR_W-1:0] < SPAN_A);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
    return IDX_W'((a - BASE_A) >> 3);
  endfunction

  logic [63:0] mem_q [DEPTH];

  w_state_e          w_state_q, w_state_d;
  logic              aw_got_q, aw_got_d, w_got_q, w_got_d;
  logic [ADDR_W-1:0] awaddr_q, awaddr_d;
  logic [63:0]       wdata_q, wdata_d;
  logic              awready_q, awready_d, wready_q, wready_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              aw_hs, w_hs, mem_we;
  logic [ADDR_W-1:0] wr_addr;
  logic [63:0]       wr_data;
`ifdef AXI_SLV_WSTRB_EN
  logic [7:0]        wstrb_q, wstrb_d, wr_strb;
`endif

  r_state_e    r_state_q, r_state_d;
  logic        arready_q, arready_d;
  logic [63:0] rdata_q, rdata_d;
  logic [1:0]  rresp_q, rresp_d;

  assign S_DM_AXI.AWREADY = awready_q;
  assign S_DM_AXI.WREADY  = wready_q;
  assign S_DM_AXI.BVALID  = (w_state_q == W_RESP);
  assign S_DM_AXI.BRESP   = bresp_q;
  assign S_DM_AXI.ARREADY = arready_q;
  assign S_DM_AXI.RVALID  = (r_state_q == R_DATA);
  assign S_DM_AXI.RDATA   = rdata_q;
  assign S_DM_AXI.RRESP   = rresp_q;

  // Write path next state: capture AW/W in any order, commit when the pair completes.
  always_comb begin
    w_state_d = w_state_q;
    aw_got_d  = aw_got_q;
    w_got_d   = w_got_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    aw_hs     = S_DM_AXI.AWVALID & awready_q;
    w_hs      = S_DM_AXI.WVALID & wready_q;
    // The beat completing the pair is used straight off the bus.
    wr_addr   = aw_got_q ? awaddr_q : S_DM_AXI.AWADDR;
    wr_data   = w_got_q ? wdata_q : S_DM_AXI.WDATA;
`ifdef AXI_SLV_WSTRB_EN
    wstrb_d   = wstrb_q;
    wr_strb   = w_got_q ? wstrb_q : S_DM_AXI.WSTRB;
`endif
    case (w_state_q)
      W_IDLE, W_HALF: begin
        if (aw_hs) begin
          aw_got_d = 1'b1;
          awaddr_d = S_DM_AXI.AWADDR;
        end
        if (w_hs) begin
          w_got_d = 1'b1;
          wdata_d = S_DM_AXI.WDATA;
`ifdef AXI_SLV_WSTRB_EN
          wstrb_d = S_DM_AXI.WSTRB;
`endif
        end
        if (aw_got_d && w_got_d) begin
          w_state_d = W_RESP;
          if (in_range(wr_addr)) begin
            mem_we  = 1'b1;
            bresp_d = OKAY;
          end else begin
            bresp_d = SLVERR;
          end
        end else if (aw_got_d || w_got_d) begin
          w_state_d = W_HALF;
        end
      end
      W_RESP: begin
        if (S_DM_AXI.BREADY) begin
          w_state_d = W_IDLE;
          aw_got_d  = 1'b0;
          w_got_d   = 1'b0;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d = (w_state_d != W_RESP) && !aw_got_d;
    wready_d  = (w_state_d != W_RESP) && !w_got_d;
  end

  // Write path registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      w_state_q <= W_IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bresp_q   <= 2'b00;
`ifdef AXI_SLV_WSTRB_EN
      wstrb_q   <= '0;
`endif
    end else begin
      w_state_q <= w_state_d;
      aw_got_q  <= aw_got_d;
      w_got_q   <= w_got_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bresp_q   <= bresp_d;
`ifdef AXI_SLV_WSTRB_EN
      wstrb_q   <= wstrb_d;
`endif
    end
  end

  // Memory array: no reset; a commit coinciding with RST is dropped.
  always_ff @(posedge CLK) begin
    if (mem_we && !RST) begin
`ifdef AXI_SLV_WSTRB_EN
      for (int i = 0; i < 8; i++) begin
        if (wr_strb[i]) mem_q[word_idx(wr_addr)][8*i +: 8] <= wr_data[8*i +: 8];
      end
`else
      mem_q[word_idx(wr_addr)] <= wr_data;
`endif
    end
  end

  // Read path next state: register the word (old value on a same-edge write).
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        if (S_DM_AXI.ARVALID && arready_q) begin
          r_state_d = R_DATA;
          if (in_range(S_DM_AXI.ARADDR)) begin
            rdata_d = mem_q[word_idx(S_DM_AXI.ARADDR)];
            rresp_d = OKAY;
          end else begin
            rdata_d = '0;
            rresp_d = SLVERR;
          end
        end
      end
      R_DATA: begin
        if (S_DM_AXI.RREADY) r_state_d = R_IDLE;
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
  end

  // Read path registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
    end else begin
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

endmodule
